dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_ack_i before aborting an access (range 1..255).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 MemRd_i  input  1  load request, driven by the EX/MEM pipeline register.
REQ-005 MemWr_i  input  1  store request, driven by the EX/MEM pipeline register.
REQ-006 addr_i  input  32  byte address (ALU result).
REQ-007 wdata_i  input  32  store data.
REQ-008 rdata_o  output  32  load data returned to the MEM/WB stage.
REQ-009 stall_o  output  1  high while an access is outstanding; the pipeline drives EX_MEM_Enable = ~stall_o.
REQ-010 err_o  output  1  sticky timeout flag.
REQ-011 mem_req_o  output  1  memory-side request.
REQ-012 mem_we_o  output  1  memory-side write enable.
REQ-013 mem_addr_o  output  32  word-aligned memory address.
REQ-014 mem_wdata_o  output  32  memory write data.
REQ-015 mem_ack_i  input  1  memory-side completion strobe (one cycle).
REQ-016 mem_rdata_i  input  32  memory read data, valid while mem_ack_i is high.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 IDLE: a request is MemRd_i|MemWr_i. On a request, stall_o SHALL be asserted combinationally in the same cycle. {addr_i[31:2],2'b00}, wdata_i and we=MemWr_i SHALL be latched, and the FSM SHALL go to ACCESS.
REQ-019 If MemRd_i and MemWr_i are both high, the access SHALL be a write.
REQ-020 ACCESS: mem_req_o=1, with mem_we_o, mem_addr_o and mem_wdata_o held stable from the latched values; stall_o=1.
REQ-021 ACCESS, on mem_ack_i: a read SHALL capture mem_rdata_i into rdata_o; mem_req_o SHALL drop in the next cycle; the FSM SHALL go to DONE.
REQ-022 DONE: stall_o=0 and mem_req_o=0 for exactly one cycle; request inputs are ignored; the FSM SHALL return to IDLE unconditionally.
REQ-023 Minimum access latency, with ack in the first ACCESS cycle, SHALL be 2 stall cycles.
REQ-024 rdata_o SHALL hold the last completed read value until the next read completes; writes leave it unchanged.
REQ-025 Timeout: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack. When the count equals TIMEOUT, the controller SHALL set err_o, drop mem_req_o, force rdata_o=32'hDEADBEEF for a read, and go to DONE.
REQ-026 If mem_ack_i and the timeout occur in the same cycle, the ack SHALL win.
REQ-027 mem_ack_i while not in ACCESS SHALL be ignored.
REQ-028 mem_addr_o[1:0] SHALL always be 2'b00; addr_i[1:0] is ignored.

Reset
REQ-029 Asserting rst_n_i at any time, including mid-ACCESS, SHALL immediately force: state IDLE, stall_o=0 (absent a request), mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0, counter=0, and (if compiled in) buffer invalid.
REQ-030 err_o SHALL clear only on reset.

Configuration
REQ-031 Macro DMEM_RDBUF_EN. When defined, a one-entry read buffer SHALL be added, holding a valid bit, tag addr[31:2] and 32-bit data.
REQ-032 With DMEM_RDBUF_EN, the buffer SHALL be filled on every read completed by ack. In IDLE, a read-only request whose tag matches a valid entry is a hit: stall_o=0 and rdata_o=buffer data combinationally, with no memory access.
REQ-033 With DMEM_RDBUF_EN, a write to the tag address SHALL update the buffer data (the write still goes to memory), and a timeout SHALL invalidate the entry.
REQ-034 Without DMEM_RDBUF_EN, there SHALL be no buffer logic and every read SHALL go to memory.

Verification
REQ-035 Read of 0x104, ack after 3 cycles with rdata 0x12345678 -> mem_addr_o=0x104, stall_o high 4 cycles, rdata_o=0x12345678 in DONE.
REQ-036 Write 0xCAFEF00D to 0x203, immediate ack -> mem_we_o=1, mem_addr_o=0x200, mem_wdata_o=0xCAFEF00D, rdata_o unchanged.
REQ-037 MemRd_i=MemWr_i=1 -> mem_we_o=1 (write).
REQ-038 TIMEOUT=4, no ack -> mem_req_o drops after 4 ACCESS cycles, err_o=1, rdata_o=0xDEADBEEF, the next access proceeds normally.
REQ-039 rst_n_i low during ACCESS -> mem_req_o=0 and all outputs at reset values in the same cycle, without a clock edge.
REQ-040 DMEM_RDBUF_EN: read 0x40 (ack 0xAA), then read 0x40 -> second read has zero stall and rdata_o=0xAA. A write of 0xBB to 0x40 followed by a read of 0x40 -> rdata_o=0xBB with zero stall.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: stalls the pipeline while a load/store is outstanding, with ack timeout.
// Optional one-entry read buffer enabled by defining DMEM_RDBUF_EN.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 30;
    localparam int unsigned CW = 8;
    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_c;
    logic          req_c;
    logic          hit_c;
    logic          unused_addr_c;

    assign req_c         = MemRd_i | MemWr_i;
    assign cnt_inc_c     = cnt_q + CW'(1);
    assign unused_addr_c = ^addr_i[1:0];

`ifdef DMEM_RDBUF_EN
    logic          buf_vld_q, buf_vld_d;
    logic [TW-1:0] buf_tag_q, buf_tag_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic          tag_match_c;

    assign tag_match_c = buf_vld_q && (buf_tag_q == addr_i[31:2]);
    assign hit_c       = (state_q == IDLE) && MemRd_i && !MemWr_i && tag_match_c;
`else
    assign hit_c = 1'b0;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef DMEM_RDBUF_EN
        buf_vld_d   = buf_vld_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit_c) begin
`ifdef DMEM_RDBUF_EN
                    rdata_d = buf_data_q;
`endif
                end else if (req_c) begin
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWr_i;
                    mem_addr_d  = {addr_i[31:2], 2'b00};
                    mem_wdata_d = wdata_i;
                    cnt_d       = '0;
`ifdef DMEM_RDBUF_EN
                    // Keep the buffered copy coherent with stores to the same word
                    if (MemWr_i && tag_match_c) begin
                        buf_data_d = wdata_i;
                    end
`endif
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata_i;
`ifdef DMEM_RDBUF_EN
                        buf_vld_d  = 1'b1;
                        buf_tag_d  = mem_addr_q[31:2];
                        buf_data_d = mem_rdata_i;
`endif
                    end
                end else if (cnt_inc_c == CW'(TIMEOUT)) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = TIMEOUT_DATA;
                    end
`ifdef DMEM_RDBUF_EN
                    buf_vld_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef DMEM_RDBUF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
        end
    end

    assign rdata_o = hit_c ? buf_data_q : rdata_q;
`else
    assign rdata_o = rdata_q;
`endif

    // Stall is raised in the request cycle itself so the EX/MEM register freezes immediately
    assign stall_o     = ((state_q == IDLE) && req_c && !hit_c) || (state_q == ACCESS);
    assign err_o       = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
